// File: rtl/sat_pkg.sv
// Shared solver types: trace-table entry layout, entry kinds and backtrack FSM states.
package sat_pkg;

  localparam int DEF_NUM_VARIABLE     = 128;
  localparam int DEF_VARIABLE_INDEXES = 8;

  typedef logic [DEF_VARIABLE_INDEXES:0] var_id_t;

  localparam logic TYPE_DECIDE = 1'b0;
  localparam logic TYPE_FORCED = 1'b1;

  typedef struct packed {
    logic    typ;
    logic    val;
    var_id_t vid;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BT_POP  = 2'd1,
    BT_PUSH = 2'd2,
    UNSAT   = 2'd3
  } bt_state_t;

endpackage

// File: rtl/backtrack_ctrl.sv
// Trace-table sequencer: arbitrates decide/implication pushes and runs chronological
// backtracking (pop to the latest Decide, re-push it flipped as Forced) on a conflict.
module backtrack_ctrl #(
  parameter int NUM_VARIABLE     = 128,
  parameter int VARIABLE_INDEXES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      decide_req,
  input  logic [VARIABLE_INDEXES:0] decide_var,
  input  logic                      decide_val,
  output logic                      decide_ready,
  input  logic                      imply_req,
  input  logic [VARIABLE_INDEXES:0] imply_var,
  input  logic                      imply_val,
  output logic                      imply_ready,
  input  logic                      conflict,
  output logic                      conflict_ready,
  output logic                      unassign_valid,
  output logic [VARIABLE_INDEXES:0] unassign_var,
  output logic                      flip_valid,
  output logic [VARIABLE_INDEXES:0] flip_var,
  output logic                      flip_val,
  output logic                      bt_done,
  output logic                      unsat,
  output logic [VARIABLE_INDEXES:0] decision_level,
  output logic [31:0]               bt_count,
  output logic                      tt_en,
  output logic                      tt_rw,
  output logic                      tt_type,
  output logic                      tt_val,
  output logic [VARIABLE_INDEXES:0] tt_variable,
  input  logic                      tt_type_out,
  input  logic                      tt_val_out,
  input  logic                      tt_empty,
  input  logic [VARIABLE_INDEXES:0] tt_variable_out
);
  import sat_pkg::*;

  localparam int                LW        = VARIABLE_INDEXES + 1;
  localparam logic [LW-1:0]     LEVEL_MAX = LW'(NUM_VARIABLE);

  bt_state_t      state;
  logic           unsat_q;
  logic           bt_done_q;
  logic [LW-1:0]  level_q;
  logic [31:0]    bt_count_q;
  logic [LW-1:0]  flip_var_q;
  logic           flip_val_q;
  logic           decide_take;
  logic           pop_decide;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [LW-1:0] level_step(input logic [LW-1:0] lvl, input logic up);
    if (up) return (lvl == LEVEL_MAX) ? lvl : lvl + LW'(1);
    return (lvl == '0) ? lvl : lvl - LW'(1);
  endfunction

  assign decide_take = (state == IDLE) && !conflict && !imply_req && decide_req;
  assign pop_decide  = (state == BT_POP) && !tt_empty && (tt_type_out == TYPE_DECIDE);

  // Handshake and trace-table drive: Mealy outputs so a push is accepted in its request cycle
  always_comb begin
    decide_ready   = 1'b0;
    imply_ready    = 1'b0;
    conflict_ready = 1'b0;
    unassign_valid = 1'b0;
    unassign_var   = '0;
    flip_valid     = 1'b0;
    flip_var       = '0;
    flip_val       = 1'b0;
    tt_en          = 1'b0;
    tt_rw          = 1'b0;
    tt_type        = 1'b0;
    tt_val         = 1'b0;
    tt_variable    = '0;
    case (state)
      IDLE: begin
        if (conflict) begin
          conflict_ready = 1'b1;
        end else if (imply_req) begin
          imply_ready = 1'b1;
          tt_en       = 1'b1;
          tt_rw       = 1'b1;
          tt_type     = TYPE_FORCED;
          tt_val      = imply_val;
          tt_variable = imply_var;
        end else if (decide_req) begin
          decide_ready = 1'b1;
          tt_en        = 1'b1;
          tt_rw        = 1'b1;
          tt_type      = TYPE_DECIDE;
          tt_val       = decide_val;
          tt_variable  = decide_var;
        end
      end
      BT_POP: begin
        if (!tt_empty) begin
          tt_en          = 1'b1;
          unassign_valid = 1'b1;
          unassign_var   = tt_variable_out;
        end
      end
      BT_PUSH: begin
        tt_en       = 1'b1;
        tt_rw       = 1'b1;
        tt_type     = TYPE_FORCED;
        tt_val      = flip_val_q;
        tt_variable = flip_var_q;
        flip_valid  = 1'b1;
        flip_var    = flip_var_q;
        flip_val    = flip_val_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      unsat_q    <= 1'b0;
      bt_done_q  <= 1'b0;
      level_q    <= '0;
      bt_count_q <= '0;
    end else begin
      bt_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (conflict) state <= BT_POP;
          else if (decide_take) level_q <= level_step(level_q, 1'b1);
        end
        BT_POP: begin
          if (tt_empty) begin
            state   <= UNSAT;
            unsat_q <= 1'b1;
          end else if (pop_decide) begin
            level_q <= level_step(level_q, 1'b0);
            state   <= BT_PUSH;
          end
        end
        BT_PUSH: begin
          state      <= IDLE;
          bt_done_q  <= 1'b1;
          bt_count_q <= sat_inc32(bt_count_q);
        end
        default: state <= UNSAT;
      endcase
    end
  end

  // The flipped decision is plain data: it is only observable while in BT_PUSH
  always_ff @(posedge clk) begin
    if (pop_decide) begin
      flip_var_q <= tt_variable_out;
      flip_val_q <= ~tt_val_out;
    end
  end

  assign bt_done        = bt_done_q;
  assign unsat          = unsat_q;
  assign decision_level = level_q;
  assign bt_count       = bt_count_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Bench for backtrack_ctrl: a stack stand-in plays the trace table; a reference stack
// predicts every push/pop/flip/done/unsat event into a scoreboard drained by a monitor.
module tb_backtrack_ctrl;
  localparam int VI = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          decide_req = 1'b0, imply_req = 1'b0, conflict = 1'b0;
  logic [VI:0]   decide_var = '0, imply_var = '0;
  logic          decide_val = 1'b0, imply_val = 1'b0;
  logic          decide_ready, imply_ready, conflict_ready;
  logic          unassign_valid, flip_valid, flip_val, bt_done, unsat;
  logic [VI:0]   unassign_var, flip_var, decision_level, tt_variable;
  logic [31:0]   bt_count;
  logic          tt_en, tt_rw, tt_type, tt_val;
  logic          tt_type_out = 1'b0, tt_val_out = 1'b0, tt_empty = 1'b1;
  logic [VI:0]   tt_variable_out = '0;

  always #5 clk = ~clk;

  backtrack_ctrl #(.NUM_VARIABLE(128), .VARIABLE_INDEXES(VI)) dut (
    .clk(clk), .reset(reset),
    .decide_req(decide_req), .decide_var(decide_var), .decide_val(decide_val), .decide_ready(decide_ready),
    .imply_req(imply_req), .imply_var(imply_var), .imply_val(imply_val), .imply_ready(imply_ready),
    .conflict(conflict), .conflict_ready(conflict_ready),
    .unassign_valid(unassign_valid), .unassign_var(unassign_var),
    .flip_valid(flip_valid), .flip_var(flip_var), .flip_val(flip_val),
    .bt_done(bt_done), .unsat(unsat), .decision_level(decision_level), .bt_count(bt_count),
    .tt_en(tt_en), .tt_rw(tt_rw), .tt_type(tt_type), .tt_val(tt_val), .tt_variable(tt_variable),
    .tt_type_out(tt_type_out), .tt_val_out(tt_val_out), .tt_empty(tt_empty),
    .tt_variable_out(tt_variable_out)
  );

  typedef struct packed { logic typ; logic val; logic [VI:0] vid; } ent_t;
  typedef enum { EV_PUSH, EV_POP, EV_FLIP, EV_DONE, EV_UNSAT } ev_kind_e;
  typedef struct { ev_kind_e kind; logic typ; logic val; logic [VI:0] vid; } ev_t;

  ent_t        tt_q[$];
  ent_t        ref_q[$];
  ev_t         exp_q[$];
  logic [31:0] ref_bt = '0;
  logic        ref_unsat = 1'b0;
  logic        unsat_prev = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // Trace table stand-in: top of stack presented combinationally, empty valid every cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) tt_q.delete();
    else if (tt_en) begin
      if (tt_rw) tt_q.push_back('{typ: tt_type, val: tt_val, vid: tt_variable});
      else if (tt_q.size() != 0) void'(tt_q.pop_back());
    end
    tt_empty <= (tt_q.size() == 0);
    if (tt_q.size() != 0) begin
      tt_type_out     <= tt_q[$].typ;
      tt_val_out      <= tt_q[$].val;
      tt_variable_out <= tt_q[$].vid;
    end else begin
      tt_type_out     <= 1'b0;
      tt_val_out      <= 1'b0;
      tt_variable_out <= '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic typ, input logic val, input logic [VI:0] vid);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got %s typ %0b val %0b var %0d, expected no event", kind.name(), typ, val, vid);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.typ !== typ || e.val !== val || e.vid !== vid) begin
      miscompares++;
      $display("FAIL event_order: got %s typ %0b val %0b var %0d, expected %s typ %0b val %0b var %0d",
               kind.name(), typ, val, vid, e.kind.name(), e.typ, e.val, e.vid);
    end
  endtask

  // Monitor: every observable DUT action is matched against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      check("stray_pop", tt_en & ~tt_rw & ~unassign_valid, 0);
      if (tt_en && tt_rw && !flip_valid) expect_ev(EV_PUSH, tt_type, tt_val, tt_variable);
      if (flip_valid) begin
        check("flip_tt_drive", {tt_en, tt_rw, tt_type, tt_val, tt_variable}, {3'b111, flip_val, flip_var});
        expect_ev(EV_FLIP, 1'b1, flip_val, flip_var);
      end
      if (unassign_valid) begin
        check("pop_tt_drive", {tt_en, tt_rw}, 2'b10);
        expect_ev(EV_POP, 1'b0, 1'b0, unassign_var);
      end
      if (bt_done) expect_ev(EV_DONE, 1'b0, 1'b0, '0);
      if (unsat && !unsat_prev) expect_ev(EV_UNSAT, 1'b0, 1'b0, '0);
      unsat_prev = unsat;
    end else begin
      unsat_prev = 1'b0;
    end
  end

  function automatic int count_decides();
    int n = 0;
    foreach (ref_q[i]) if (ref_q[i].typ == 1'b0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {decide_ready, imply_ready, conflict_ready, unassign_valid, flip_valid, flip_val,
                           bt_done, unsat, tt_en, tt_rw, tt_type, tt_val}, 0);
    check({tag, "_ids"}, {unassign_var, flip_var, decision_level, tt_variable}, 0);
    check({tag, "_bt_count"}, bt_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_outputs_zero("in_reset");
    exp_q.delete();
    ref_q.delete();
    ref_bt    = '0;
    ref_unsat = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic do_push(input bit is_dec, input logic [VI:0] v, input logic b);
    bit got = 1'b0;
    exp_q.push_back('{EV_PUSH, ~is_dec, b, v});
    ref_q.push_back('{typ: ~is_dec, val: b, vid: v});
    if (is_dec) begin decide_req = 1'b1; decide_var = v; decide_val = b; end
    else begin imply_req = 1'b1; imply_var = v; imply_val = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_dec ? decide_ready : imply_ready;
    end
    check(is_dec ? "decide_accept" : "imply_accept", got, 1);
    step();
    decide_req = 1'b0;
    imply_req  = 1'b0;
    check("level_after_push", decision_level, count_decides());
  endtask

  task automatic do_conflict(input bit with_others, output int lat);
    int   idx = -1;
    int   exp_lat;
    bit   got = 1'b0;
    ent_t fe;
    for (int i = ref_q.size() - 1; i >= 0 && idx < 0; i--) if (ref_q[i].typ == 1'b0) idx = i;
    for (int i = ref_q.size() - 1; i >= ((idx < 0) ? 0 : idx); i--)
      exp_q.push_back('{EV_POP, 1'b0, 1'b0, ref_q[i].vid});
    if (idx >= 0) begin
      fe = '{typ: 1'b1, val: ~ref_q[idx].val, vid: ref_q[idx].vid};
      exp_q.push_back('{EV_FLIP, 1'b1, fe.val, fe.vid});
      exp_q.push_back('{EV_DONE, 1'b0, 1'b0, '0});
      exp_lat = ref_q.size() - idx + 2;
      while (ref_q.size() > idx) void'(ref_q.pop_back());
      ref_q.push_back(fe);
      if (ref_bt != 32'hFFFF_FFFF) ref_bt++;
    end else begin
      exp_q.push_back('{EV_UNSAT, 1'b0, 1'b0, '0});
      exp_lat = ref_q.size() + 2;
      ref_q.delete();
      ref_unsat = 1'b1;
    end
    conflict = 1'b1;
    if (with_others) begin
      imply_req  = 1'b1; imply_var  = 9'($urandom_range(0, 511)); imply_val  = 1'($urandom_range(0, 1));
      decide_req = 1'b1; decide_var = 9'($urandom_range(0, 511)); decide_val = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = conflict_ready;
    end
    check("conflict_accept", got, 1);
    if (with_others) begin
      check("arb_imply_ready", imply_ready, 0);
      check("arb_decide_ready", decide_ready, 0);
      check("arb_no_push", tt_en, 0);
    end
    step();
    conflict   = 1'b0;
    imply_req  = 1'b0;
    decide_req = 1'b0;
    lat = -1;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(negedge clk);
      if ((idx >= 0) ? bt_done : unsat) lat = c;
    end
    check("done_latency", lat, exp_lat);
    step();
    check("level_after_bt", decision_level, count_decides());
    check("bt_count", bt_count, ref_bt);
    check("unsat_flag", unsat, ref_unsat);
  endtask

  initial begin
    int lat;
    int r;
    bit got;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("power_on");
    reset = 1'b1;
    step();

    // Decide x3=1, Forced x5=0, Forced x7=1, then conflict
    do_push(1'b1, 9'd3, 1'b1);
    do_push(1'b0, 9'd5, 1'b0);
    do_push(1'b0, 9'd7, 1'b1);
    check("tp1_level_before", decision_level, 1);
    do_conflict(1'b0, lat);
    check("tp1_latency", lat, 5);
    check("tp1_level_after", decision_level, 0);
    check("tp1_bt_count", bt_count, 1);

    // Forced-only stack runs empty: UNSAT is sticky and stalls requesters
    do_reset();
    do_push(1'b0, 9'd1, 1'b1);
    do_push(1'b0, 9'd2, 1'b0);
    do_conflict(1'b0, lat);
    check("tp2_unsat_latency", lat, 4);
    decide_req = 1'b1;
    decide_var = 9'd9;
    repeat (5) begin
      @(negedge clk);
      check("tp2_decide_ready_held", decide_ready, 0);
      check("tp2_unsat_sticky", unsat, 1);
    end
    step();
    decide_req = 1'b0;

    // Conflict, imply and decide together: conflict wins
    do_reset();
    do_push(1'b1, 9'd4, 1'b1);
    do_conflict(1'b1, lat);
    check("tp3_latency", lat, 3);

    // Empty stack conflict
    do_reset();
    do_conflict(1'b0, lat);
    check("tp4_unsat_latency", lat, 2);

    // Reset in the second BT_POP cycle
    do_reset();
    do_push(1'b1, 9'd10, 1'b1);
    do_push(1'b0, 9'd11, 1'b0);
    do_push(1'b0, 9'd12, 1'b1);
    exp_q.push_back('{EV_POP, 1'b0, 1'b0, 9'd12});
    conflict = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = conflict_ready;
    end
    check("tp5_accept", got, 1);
    step();
    conflict = 1'b0;
    @(negedge clk);
    check("tp5_first_pop", unassign_valid, 1);
    step();
    check("tp5_second_pop_var", {unassign_valid, unassign_var}, {1'b1, 9'd11});
    do_reset();
    do_push(1'b1, 9'd20, 1'b0);
    check("tp5_level_after_reset", decision_level, 1);

    // Nested decisions, two backtracks
    do_reset();
    do_push(1'b1, 9'd1, 1'b1);
    do_push(1'b1, 9'd2, 1'b0);
    do_conflict(1'b0, lat);
    check("tp6_first_latency", lat, 3);
    do_conflict(1'b0, lat);
    check("tp6_second_latency", lat, 4);
    check("tp6_bt_count", bt_count, 2);
    check("tp6_level", decision_level, 0);

    // Randomized traffic against the reference stack
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (ref_q.size() >= 100 || r >= 8) begin
        do_conflict(1'($urandom_range(0, 1)), lat);
        if (ref_unsat) do_reset();
      end else begin
        do_push(r < 4, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
